// File: rtl/sdram_slot_arbiter_pkg.sv
// rtl/sdram_slot_arbiter_pkg.sv - owner codes and FSM state encodings for the SDRAM slot arbiter
package sdram_slot_arbiter_pkg;

    // Owner of the current slot
    localparam logic [2:0] OWN_NONE = 3'd0;
    localparam logic [2:0] OWN_REF  = 3'd1;
    localparam logic [2:0] OWN_CHIP = 3'd2;
    localparam logic [2:0] OWN_CPU  = 3'd3;
    localparam logic [2:0] OWN_HOST = 3'd4;

    // Slot FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARB   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational requester priority with host anti-starvation promotion
module sdram_arb_pick
    import sdram_slot_arbiter_pkg::*;
#(
    parameter int HOST_STARVE = 8,
    parameter int SW          = 4
) (
    input  logic          refresh_req,
    input  logic          chip_req,
    input  logic          cpu_req,
    input  logic          host_req,
    input  logic [SW-1:0] starve,
    output logic [2:0]    owner
);

    logic host_starved;

    assign host_starved = (starve == SW'(HOST_STARVE));

    // refresh > chip > starved host > cpu > host
    always_comb begin
        owner = OWN_NONE;
        if (refresh_req) begin
            owner = OWN_REF;
        end else if (chip_req) begin
            owner = OWN_CHIP;
        end else if (host_req && host_starved) begin
            owner = OWN_HOST;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (host_req) begin
            owner = OWN_HOST;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// rtl/sdram_slot_arbiter.sv - one SDRAM access per 7 MHz slot shared among refresh, chip, cpu and host
module sdram_slot_arbiter
    import sdram_slot_arbiter_pkg::*;
#(
    parameter int AW          = 24,
    parameter int DW          = 16,
    parameter int HOST_STARVE = 8
) (
    input  logic          clk,
    input  logic          _rst,
    input  logic          slot_sync,
    input  logic          refresh_req,
    output logic          sd_refresh,
    input  logic          chip_req,
    input  logic          chip_we,
    input  logic [AW-1:0] chip_adr,
    input  logic [1:0]    chip_be,
    input  logic [DW-1:0] chip_wdat,
    output logic [DW-1:0] chip_rdat,
    output logic          chip_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [1:0]    cpu_be,
    input  logic [DW-1:0] cpu_wdat,
    output logic [DW-1:0] cpu_rdat,
    output logic          cpu_ack,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_adr,
    input  logic [1:0]    host_be,
    input  logic [DW-1:0] host_wdat,
    output logic [DW-1:0] host_rdat,
    output logic          host_ack,
    output logic          sd_start,
    output logic          sd_we,
    output logic [AW-1:0] sd_adr,
    output logic [1:0]    sd_be,
    output logic [DW-1:0] sd_wdat,
    input  logic [DW-1:0] sd_rdat,
    input  logic          sd_rvalid,
    input  logic          sd_done,
    output logic          overrun
);

    localparam int SW = $clog2(HOST_STARVE + 1);

    logic [2:0]    state;
    logic [2:0]    owner;
    logic [2:0]    pick;
    logic [SW-1:0] starve;
    logic          arb_now;
    logic          busy;

    sdram_arb_pick #(
        .HOST_STARVE (HOST_STARVE),
        .SW          (SW)
    ) u_pick (
        .refresh_req (refresh_req),
        .chip_req    (chip_req),
        .cpu_req     (cpu_req),
        .host_req    (host_req),
        .starve      (starve),
        .owner       (pick)
    );

    // A slot_sync landing in ACK still belongs to a command that finished in time, so it is arbitrated
    assign arb_now = slot_sync && ((state == ST_IDLE) || (state == ST_ACK));
    assign busy    = (state == ST_ISSUE) || (state == ST_WAIT);

    assign sd_start   = (state == ST_ISSUE);
    assign sd_refresh = (state == ST_ISSUE) && (owner == OWN_REF);
    assign chip_ack   = (state == ST_ACK) && (owner == OWN_CHIP);
    assign cpu_ack    = (state == ST_ACK) && (owner == OWN_CPU);
    assign host_ack   = (state == ST_ACK) && (owner == OWN_HOST);

    // Slot FSM, owner latch and sticky overrun flag
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_NONE;
            overrun <= 1'b0;
        end else begin
            if (busy && slot_sync) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_ACK: begin
                    if (arb_now) begin
                        owner <= pick;
                        state <= ST_ARB;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    state <= (owner == OWN_NONE) ? ST_IDLE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= sd_done ? ST_ACK : ST_WAIT;
                end
                ST_WAIT: begin
                    if (sd_done) begin
                        state <= ST_ACK;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Host starvation counter, updated at every arbitration point
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            starve <= '0;
        end else if (arb_now) begin
            if (!host_req || (pick == OWN_HOST)) begin
                starve <= '0;
            end else if (starve != SW'(HOST_STARVE)) begin
                starve <= starve + SW'(1);
            end
        end
    end

    // Command fields are loaded in ARB and then held until the next slot is arbitrated
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            sd_we   <= 1'b0;
            sd_adr  <= '0;
            sd_be   <= '0;
            sd_wdat <= '0;
        end else if (state == ST_ARB) begin
            case (owner)
                OWN_REF: begin
                    sd_we   <= 1'b0;
                    sd_adr  <= '0;
                    sd_be   <= '0;
                    sd_wdat <= '0;
                end
                OWN_CHIP: begin
                    sd_we   <= chip_we;
                    sd_adr  <= chip_adr;
                    sd_be   <= chip_be;
                    sd_wdat <= chip_wdat;
                end
                OWN_CPU: begin
                    sd_we   <= cpu_we;
                    sd_adr  <= cpu_adr;
                    sd_be   <= cpu_be;
                    sd_wdat <= cpu_wdat;
                end
                OWN_HOST: begin
                    sd_we   <= host_we;
                    sd_adr  <= host_adr;
                    sd_be   <= host_be;
                    sd_wdat <= host_wdat;
                end
                default: begin
                end
            endcase
        end
    end

    // Read data capture into the owner's holding register
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            chip_rdat <= '0;
            cpu_rdat  <= '0;
            host_rdat <= '0;
        end else if (busy && sd_rvalid && !sd_we) begin
            case (owner)
                OWN_CHIP: chip_rdat <= sd_rdat;
                OWN_CPU:  cpu_rdat  <= sd_rdat;
                OWN_HOST: host_rdat <= sd_rdat;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb/tb_sdram_slot_arbiter.sv - randomized self-checking bench for sdram_slot_arbiter
module tb_sdram_slot_arbiter;

    localparam int W_NONE = 0;
    localparam int W_REF  = 1;
    localparam int W_CHIP = 2;
    localparam int W_CPU  = 3;
    localparam int W_HOST = 4;

    logic        clk = 1'b0;
    logic        _rst;
    logic        slot_sync, refresh_req, sd_refresh;
    logic        chip_req, chip_we, chip_ack;
    logic [23:0] chip_adr;
    logic [1:0]  chip_be;
    logic [15:0] chip_wdat, chip_rdat;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [23:0] cpu_adr;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_wdat, cpu_rdat;
    logic        host_req, host_we, host_ack;
    logic [23:0] host_adr;
    logic [1:0]  host_be;
    logic [15:0] host_wdat, host_rdat;
    logic        sd_start, sd_we, sd_rvalid, sd_done, overrun;
    logic [23:0] sd_adr;
    logic [1:0]  sd_be;
    logic [15:0] sd_wdat, sd_rdat;
    logic [96:0] outs;

    int total = 0;
    int bad   = 0;
    int starve_m;
    logic [15:0] exp_rdat [0:4];
    logic        exp_ovr;

    always #5 clk = ~clk;

    assign outs = {sd_start, sd_refresh, sd_we, sd_adr, sd_be, sd_wdat, chip_ack, cpu_ack, host_ack,
                   chip_rdat, cpu_rdat, host_rdat, overrun};

    sdram_slot_arbiter dut (
        .clk(clk), ._rst(_rst), .slot_sync(slot_sync), .refresh_req(refresh_req), .sd_refresh(sd_refresh),
        .chip_req(chip_req), .chip_we(chip_we), .chip_adr(chip_adr), .chip_be(chip_be),
        .chip_wdat(chip_wdat), .chip_rdat(chip_rdat), .chip_ack(chip_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_be(cpu_be),
        .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat), .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_be(host_be),
        .host_wdat(host_wdat), .host_rdat(host_rdat), .host_ack(host_ack),
        .sd_start(sd_start), .sd_we(sd_we), .sd_adr(sd_adr), .sd_be(sd_be), .sd_wdat(sd_wdat),
        .sd_rdat(sd_rdat), .sd_rvalid(sd_rvalid), .sd_done(sd_done), .overrun(overrun)
    );

    // Reference arbitration: priority rules plus starvation bookkeeping on plain integers
    function automatic int model_pick();
        int w;
        if (refresh_req)                    w = W_REF;
        else if (chip_req)                  w = W_CHIP;
        else if (host_req && starve_m >= 8) w = W_HOST;
        else if (cpu_req)                   w = W_CPU;
        else if (host_req)                  w = W_HOST;
        else                                w = W_NONE;
        if (host_req && w != W_HOST) starve_m = (starve_m < 8) ? starve_m + 1 : 8;
        else                         starve_m = 0;
        return w;
    endfunction

    task automatic clear_inputs();
        slot_sync = 0; refresh_req = 0; sd_rdat = 0; sd_rvalid = 0; sd_done = 0;
        chip_req = 0; chip_we = 0; chip_adr = 0; chip_be = 0; chip_wdat = 0;
        cpu_req = 0;  cpu_we = 0;  cpu_adr = 0;  cpu_be = 0;  cpu_wdat = 0;
        host_req = 0; host_we = 0; host_adr = 0; host_be = 0; host_wdat = 0;
    endtask

    task automatic model_reset();
        starve_m = 0;
        exp_ovr  = 0;
        for (int i = 0; i < 5; i++) exp_rdat[i] = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        _rst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        _rst = 1;
        model_reset();
    endtask

    task automatic set_req(input int who, input logic we);
        case (who)
            W_CHIP: begin chip_req = 1; chip_we = we; chip_adr = 24'($urandom); chip_be = 2'($urandom); chip_wdat = 16'($urandom); end
            W_CPU:  begin cpu_req = 1;  cpu_we = we;  cpu_adr = 24'($urandom);  cpu_be = 2'($urandom);  cpu_wdat = 16'($urandom);  end
            W_HOST: begin host_req = 1; host_we = we; host_adr = 24'($urandom); host_be = 2'($urandom); host_wdat = 16'($urandom); end
            default: begin end
        endcase
    endtask

    // One full slot: slot_sync, predicted grant, sequencer response after lat clocks, ack checks
    task automatic run_slot(input int lat, input logic [15:0] rd, input bit drop, output int won);
        int          w;
        logic [42:0] exp_f;
        logic        saw_ref;
        w = model_pick();
        case (w)
            W_CHIP:  exp_f = {chip_we, chip_adr, chip_be, chip_wdat};
            W_CPU:   exp_f = {cpu_we, cpu_adr, cpu_be, cpu_wdat};
            W_HOST:  exp_f = {host_we, host_adr, host_be, host_wdat};
            default: exp_f = '0;
        endcase
        won = W_NONE;
        @(negedge clk); slot_sync = 1;
        @(negedge clk); slot_sync = 0;
        total++;
        if (sd_start !== 1'b0) begin bad++; $display("FAIL start_early: got %b want 0", sd_start); end
        @(negedge clk);
        total++;
        if (sd_start !== (w != W_NONE)) begin bad++; $display("FAIL sd_start: got %b want %b", sd_start, w != W_NONE); end
        if (w != W_NONE) begin
            saw_ref = sd_refresh;
            total++;
            if (sd_refresh !== (w == W_REF)) begin bad++; $display("FAIL sd_refresh: got %b want %b", sd_refresh, w == W_REF); end
            total++;
            if ({sd_we, sd_adr, sd_be, sd_wdat} !== exp_f) begin
                bad++; $display("FAIL sd_fields: got %h want %h", {sd_we, sd_adr, sd_be, sd_wdat}, exp_f);
            end
            repeat (lat) @(negedge clk);
            total++;
            if ({chip_ack, cpu_ack, host_ack} !== 3'b000) begin bad++; $display("FAIL ack_early: got %b want 000", {chip_ack, cpu_ack, host_ack}); end
            sd_done   = 1;
            sd_rvalid = (w != W_REF) && !exp_f[42];
            sd_rdat   = rd;
            if (sd_rvalid) exp_rdat[w] = rd;
            @(negedge clk);
            sd_done = 0; sd_rvalid = 0; sd_rdat = 16'($urandom);
            total++;
            if ({chip_ack, cpu_ack, host_ack} !== {w == W_CHIP, w == W_CPU, w == W_HOST}) begin
                bad++; $display("FAIL acks: got %b want %b", {chip_ack, cpu_ack, host_ack}, {w == W_CHIP, w == W_CPU, w == W_HOST});
            end
            total++;
            if ({chip_rdat, cpu_rdat, host_rdat} !== {exp_rdat[W_CHIP], exp_rdat[W_CPU], exp_rdat[W_HOST]}) begin
                bad++; $display("FAIL rdat: got %h want %h", {chip_rdat, cpu_rdat, host_rdat},
                                {exp_rdat[W_CHIP], exp_rdat[W_CPU], exp_rdat[W_HOST]});
            end
            total++;
            if (overrun !== exp_ovr) begin bad++; $display("FAIL overrun_slot: got %b want %b", overrun, exp_ovr); end
            if (chip_ack)     won = W_CHIP;
            else if (cpu_ack) won = W_CPU;
            else if (host_ack) won = W_HOST;
            else if (saw_ref) won = W_REF;
            if (drop) begin
                case (w)
                    W_REF:  refresh_req = 0;
                    W_CHIP: chip_req = 0;
                    W_CPU:  cpu_req = 0;
                    W_HOST: host_req = 0;
                    default: begin end
                endcase
            end
        end
    endtask

    task automatic test_reset();
        int w;
        _rst = 0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_initial: got %h want 0", outs); end
        _rst = 1;
        set_req(W_CPU, 0);
        run_slot(3, 16'h1234, 1, w);
        set_req(W_CPU, 0);
        w = model_pick();
        @(negedge clk); slot_sync = 1;
        @(negedge clk); slot_sync = 0;
        repeat (3) @(negedge clk);
        _rst = 0;
        #1;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_midwait: got %h want 0", outs); end
        @(negedge clk);
        _rst = 1;
        model_reset();
        begin
            bit started = 0;
            repeat (20) begin
                @(negedge clk);
                if (sd_start) started = 1;
            end
            total++;
            if (started) begin bad++; $display("FAIL start_without_sync: got 1 want 0"); end
        end
        run_slot(2, 16'h0F0F, 1, w);
        total++;
        if (w != W_CPU) begin bad++; $display("FAIL reset_first_grant: got %0d want %0d", w, W_CPU); end
    endtask

    task automatic test_chip_vs_cpu();
        int w;
        do_reset();
        set_req(W_CHIP, 1);
        chip_adr = 24'h00_1234;
        set_req(W_CPU, 1);
        run_slot(4, 16'h0, 1, w);
        total++;
        if (w != W_CHIP) begin bad++; $display("FAIL chip_first: got %0d want %0d", w, W_CHIP); end
        run_slot(2, 16'h0, 1, w);
        total++;
        if (w != W_CPU) begin bad++; $display("FAIL cpu_next: got %0d want %0d", w, W_CPU); end
    endtask

    task automatic test_read_data();
        int w;
        do_reset();
        set_req(W_CHIP, 0);
        run_slot(3, 16'h1111, 1, w);
        set_req(W_CPU, 0);
        run_slot(5, 16'hBEEF, 1, w);
        total++;
        if (cpu_rdat !== 16'hBEEF) begin bad++; $display("FAIL cpu_rdat: got %h want beef", cpu_rdat); end
        total++;
        if (chip_rdat !== 16'h1111) begin bad++; $display("FAIL chip_rdat_kept: got %h want 1111", chip_rdat); end
        set_req(W_CPU, 1);
        run_slot(2, 16'h5555, 1, w);
        total++;
        if (cpu_rdat !== 16'hBEEF) begin bad++; $display("FAIL write_keeps_rdat: got %h want beef", cpu_rdat); end
    endtask

    task automatic test_starvation();
        int wins [10];
        do_reset();
        set_req(W_CPU, 0);
        set_req(W_HOST, 1);
        for (int i = 0; i < 10; i++) run_slot(2, 16'($urandom), 0, wins[i]);
        total++;
        if (wins[7] != W_CPU) begin bad++; $display("FAIL starve_slot8: got %0d want %0d", wins[7], W_CPU); end
        total++;
        if (wins[8] != W_HOST) begin bad++; $display("FAIL starve_slot9: got %0d want %0d", wins[8], W_HOST); end
        total++;
        if (wins[9] != W_CPU) begin bad++; $display("FAIL starve_slot10: got %0d want %0d", wins[9], W_CPU); end
        cpu_req = 0;
        host_req = 0;
    endtask

    task automatic test_refresh();
        int w;
        do_reset();
        refresh_req = 1;
        set_req(W_CHIP, 0);
        run_slot(3, 16'hAAAA, 1, w);
        total++;
        if (w != W_REF) begin bad++; $display("FAIL refresh_grant: got %0d want %0d", w, W_REF); end
        run_slot(3, 16'h7777, 1, w);
        total++;
        if (w != W_CHIP) begin bad++; $display("FAIL chip_after_refresh: got %0d want %0d", w, W_CHIP); end
    endtask

    task automatic test_overrun();
        int          w;
        logic [15:0] rd;
        do_reset();
        set_req(W_CPU, 1);
        w = model_pick();
        @(negedge clk); slot_sync = 1;
        @(negedge clk); slot_sync = 0;
        @(negedge clk);
        total++;
        if (sd_start !== 1'b1) begin bad++; $display("FAIL ovr_start: got %b want 1", sd_start); end
        repeat (3) @(negedge clk);
        slot_sync = 1;
        @(negedge clk); slot_sync = 0;
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        @(negedge clk);
        total++;
        if (sd_start !== 1'b0) begin bad++; $display("FAIL ovr_skip: got %b want 0", sd_start); end
        sd_done = 1;
        @(negedge clk); sd_done = 0;
        total++;
        if (cpu_ack !== 1'b1) begin bad++; $display("FAIL ovr_late_ack: got %b want 1", cpu_ack); end
        cpu_req = 0;
        repeat (3) @(negedge clk);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        exp_ovr = 1;
        set_req(W_HOST, 1);
        run_slot(3, 16'h0, 1, w);
        do_reset();
        @(negedge clk);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
        set_req(W_CHIP, 0);
        w = model_pick();
        @(negedge clk); slot_sync = 1;
        @(negedge clk); slot_sync = 0;
        repeat (3) @(negedge clk);
        rd = 16'($urandom);
        slot_sync = 1; sd_done = 1; sd_rvalid = 1; sd_rdat = rd;
        @(negedge clk);
        slot_sync = 0; sd_done = 0; sd_rvalid = 0;
        total++;
        if (chip_ack !== 1'b1) begin bad++; $display("FAIL same_clk_ack: got %b want 1", chip_ack); end
        total++;
        if (chip_rdat !== rd) begin bad++; $display("FAIL same_clk_rdat: got %h want %h", chip_rdat, rd); end
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL same_clk_ovr: got %b want 1", overrun); end
        chip_req = 0;
        @(negedge clk);
        total++;
        if (sd_start !== 1'b0) begin bad++; $display("FAIL same_clk_skip: got %b want 0", sd_start); end
        exp_rdat[W_CHIP] = rd;
        exp_ovr = 1;
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (!chip_req && $urandom_range(0, 2) == 0) set_req(W_CHIP, 1'($urandom));
            if (!cpu_req  && $urandom_range(0, 1) == 0) set_req(W_CPU,  1'($urandom));
            if (!host_req && $urandom_range(0, 1) == 0) set_req(W_HOST, 1'($urandom));
            refresh_req = ($urandom_range(0, 4) == 0);
            run_slot($urandom_range(1, 8), 16'($urandom), 1, w);
            refresh_req = 0;
        end
    endtask

    initial begin
        test_reset();
        test_chip_vs_cpu();
        test_read_data();
        test_starvation();
        test_refresh();
        test_overrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
